// File: rtl/ysyx_22050078_memresp_if.sv
// Request/response handshake bundle between an initiator and the memresp responder.
interface ysyx_22050078_memresp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22050078_memresp.sv
// Single-outstanding 64-bit word memory responder with fixed response latency,
// byte-masked stores and an out-of-range error response.
module ysyx_22050078_memresp #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22050078_memresp_if.slave   bus
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = 4;
    localparam logic [63:0] SPAN      = 64'(DEPTH) << 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic        ONE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [63:0]       rdata_q, rdata_d;

    logic [63:0]       mem [DEPTH];

    logic [63:0]       offset_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;
    logic              accept_c;

    // Unsigned subtract plus lower-bound test keeps addresses below the base from wrapping in.
    assign offset_c   = bus.req_addr - BASE_ADDR;
    assign in_range_c = (bus.req_addr >= BASE_ADDR) && (offset_c < SPAN);
    assign idx_c      = offset_c[IDX_W+2:3];
    assign accept_c   = ready_q && bus.req_valid;

    // Next-state and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cnt_d   = CNT_LOAD;
                    err_d   = !in_range_c;
                    rdata_d = (!bus.req_wen && in_range_c) ? mem[idx_c] : 64'h0;
                    state_d = ONE_CYCLE ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    // State register; reset wins over any acceptance on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is not reset; stores commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (!rst && accept_c && bus.req_wen && in_range_c) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.req_wmask[b]) begin
                    mem[idx_c][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22050078_memresp.sv
// Scoreboard bench for ysyx_22050078_memresp: driver pushes model expectations,
// a negedge monitor pops and compares each response.
module tb_ysyx_22050078_memresp;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam logic [63:0] TOP   = BASE + 64'(8 * DEPTH);

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic [63:0] cmask;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pcyc = 0;
    int   total = 0;
    int   passed = 0;
    int   mode = 0;

    exp_t        sbq[$];
    logic [63:0] ref_mem   [int];
    logic [7:0]  ref_known [int];

    logic        in_rsp = 1'b0;
    logic        hs_prev = 1'b0;
    logic        rst_prev = 1'b0;
    int          since_rst = 0;
    int          nheld = 0;
    logic [63:0] held_rdata = 64'h0;
    logic        held_err = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    ysyx_22050078_memresp_if bus ();

    ysyx_22050078_memresp #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, exp, pcyc);
    endfunction

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    // Reference memory: word map plus per-byte "ever written" mask.
    function automatic exp_t model(input logic wen, input logic [63:0] addr,
                                   input logic [63:0] wdata, input logic [7:0] wmask,
                                   input int due);
        exp_t e;
        int   idx;
        e.due   = due;
        e.rdata = 64'h0;
        e.err   = 1'b0;
        e.cmask = '1;
        if (addr < BASE || addr >= TOP) begin
            e.err = 1'b1;
        end else begin
            idx = int'((addr - BASE) >> 3);
            if (!ref_mem.exists(idx)) begin
                ref_mem[idx]   = 64'h0;
                ref_known[idx] = 8'h00;
            end
            if (wen) begin
                ref_mem[idx]   = (ref_mem[idx] & ~lanes(wmask)) | (wdata & lanes(wmask));
                ref_known[idx] = ref_known[idx] | wmask;
            end else begin
                e.rdata = ref_mem[idx];
                e.cmask = lanes(ref_known[idx]);
            end
        end
        return e;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
    task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, output int acc);
        int guard = 0;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && guard < 100) begin
            wait_cycles(1);
            guard++;
        end
        chk(bus.req_ready == 1'b1, "req_accept", 64'(bus.req_ready), 64'h1);
        if (bus.req_ready) begin
            acc = pcyc;
            sbq.push_back(model(wen, addr, wdata, wmask, pcyc + int'(LAT)));
            wait_cycles(1);
        end else begin
            acc = -1;
        end
        bus.req_valid = 1'b0;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        bus.req_wmask = 8'($urandom);
        bus.req_wen   = 1'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while ((sbq.size() != 0 || in_rsp) && guard < 500) begin
            wait_cycles(1);
            guard++;
        end
        wait_cycles(2);
        chk(sbq.size() == 0 && !in_rsp, "drain", 64'(sbq.size()), 64'h0);
    endtask

    // Monitor: samples at negedge, then drives rsp_ready for the coming edge.
    always @(negedge clk) begin
        logic nr;
        exp_t e;
        if (rst) begin
            if (rst_prev) begin
                chk(bus.rsp_valid == 1'b0, "rst_valid", 64'(bus.rsp_valid), 64'h0);
                chk(bus.req_ready == 1'b0, "rst_ready", 64'(bus.req_ready), 64'h0);
                chk(bus.rsp_err == 1'b0, "rst_err", 64'(bus.rsp_err), 64'h0);
                chk(bus.rsp_rdata == 64'h0, "rst_rdata", bus.rsp_rdata, 64'h0);
            end
            sbq.delete();
            in_rsp    = 1'b0;
            hs_prev   = 1'b0;
            since_rst = 0;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (since_rst < 3) since_rst++;
            if (since_rst == 2)
                chk(bus.req_ready == 1'b1, "ready_after_rst", 64'(bus.req_ready), 64'h1);
            if (hs_prev) begin
                chk(bus.rsp_valid == 1'b0, "valid_after_hs", 64'(bus.rsp_valid), 64'h0);
                chk(bus.req_ready == 1'b1, "ready_after_hs", 64'(bus.req_ready), 64'h1);
                hs_prev = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    chk(sbq.size() != 0, "rsp_unexpected", 64'(sbq.size()), 64'h1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk(pcyc == e.due, "rsp_latency", 64'(pcyc), 64'(e.due));
                        chk(((bus.rsp_rdata ^ e.rdata) & e.cmask) == 64'h0, "rsp_rdata",
                            bus.rsp_rdata, e.rdata);
                        chk(bus.rsp_err == e.err, "rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    in_rsp     = 1'b1;
                    nheld      = 0;
                    held_rdata = bus.rsp_rdata;
                    held_err   = bus.rsp_err;
                end else begin
                    chk(bus.rsp_rdata == held_rdata, "hold_rdata", bus.rsp_rdata, held_rdata);
                    chk(bus.rsp_err == held_err, "hold_err", 64'(bus.rsp_err), 64'(held_err));
                end
                chk(bus.req_ready == 1'b0, "ready_in_resp", 64'(bus.req_ready), 64'h0);
                nheld++;
            end else begin
                if (in_rsp) begin
                    chk(bus.rsp_valid == 1'b1, "rsp_dropped", 64'(bus.rsp_valid), 64'h1);
                    in_rsp = 1'b0;
                end
                if (sbq.size() != 0 && pcyc >= sbq[0].due) begin
                    chk(bus.rsp_valid == 1'b1, "rsp_missing", 64'(pcyc), 64'(sbq[0].due));
                    void'(sbq.pop_front());
                end
            end
        end
        case (mode)
            0:       nr = 1'b1;
            1:       nr = ($urandom_range(0, 3) != 0);
            default: nr = in_rsp && (nheld >= 6);
        endcase
        bus.rsp_ready = nr;
        if (!rst && in_rsp && nr) begin
            in_rsp  = 1'b0;
            hs_prev = 1'b1;
        end
    end

    initial begin
        int          acc;
        int          prev;
        int          r;
        logic [63:0] a;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 64'h0;
        bus.req_wdata = 64'h0;
        bus.req_wmask = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_cycles(3);

        // Full store then load, then a half-word masked overwrite.
        mode = 0;
        issue(1'b1, BASE + 64'h10, 64'h1122334455667788, 8'hFF, acc);
        issue(1'b0, BASE + 64'h10, 64'h0, 8'h00, acc);
        issue(1'b1, BASE + 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, acc);
        issue(1'b0, BASE + 64'h10, 64'h0, 8'h00, acc);

        // Range edges: below base, one past the end, last word, top of address space.
        issue(1'b1, BASE, 64'h0123_4567_89AB_CDEF, 8'hFF, acc);
        issue(1'b0, 64'h0000_0000_7FFF_FFF8, 64'h0, 8'h00, acc);
        issue(1'b1, 64'h0000_0000_8000_0800, 64'hFFFF_0000_FFFF_0000, 8'hFF, acc);
        issue(1'b0, BASE, 64'h0, 8'h00, acc);
        issue(1'b1, TOP - 64'h8, 64'hCAFE_F00D_1234_5678, 8'hFF, acc);
        issue(1'b0, TOP - 64'h1, 64'h0, 8'h00, acc);
        issue(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, acc);
        issue(1'b1, BASE + 64'h10, 64'h5555_5555_5555_5555, 8'h00, acc);
        issue(1'b0, BASE + 64'h10, 64'h0, 8'h00, acc);

        // Backpressure: ready held low for five response cycles.
        mode = 2;
        issue(1'b0, BASE + 64'h10, 64'h0, 8'h00, acc);
        issue(1'b0, TOP, 64'h0, 8'h00, acc);
        drain();
        mode = 0;

        // Reset while the store is in flight; a store presented during reset must not land.
        issue(1'b1, BASE + 64'h20, 64'h0000_0000_0000_DEAD, 8'hFF, acc);
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = BASE + 64'h20;
        bus.req_wdata = 64'h0000_0000_0000_BEEF;
        bus.req_wmask = 8'hFF;
        wait_cycles(2);
        bus.req_valid = 1'b0;
        rst           = 1'b0;
        wait_cycles(3);
        issue(1'b0, BASE + 64'h20, 64'h0, 8'h00, acc);
        drain();

        // Randomized traffic with random backpressure and idle gaps.
        mode = 1;
        for (int i = 0; i < 150; i++) begin
            wait_cycles(int'($urandom_range(0, 2)));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = BASE - 64'($urandom_range(1, 64));
            else if (r == 1) a = TOP + 64'($urandom_range(0, 64));
            else             a = BASE + 64'($urandom_range(0, 127));
            issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), acc);
        end
        mode = 0;
        drain();

        // Back-to-back with ready always high: one transaction per LAT+1 cycles.
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            issue((i % 2) == 0, BASE + 64'(8 * (i / 2)), {$urandom, $urandom}, 8'hFF, acc);
            if (i > 0)
                chk(acc - prev == int'(LAT) + 1, "b2b_spacing", 64'(acc - prev), 64'(LAT + 1));
            prev = acc;
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
